// File: rtl/gray_step_decoder.sv
// Decodes a 3-bit reflected Gray code into position/direction, classifies each
// sampled step and tracks lock and error statistics with an IDLE/ACQ/LOCK FSM.
module gray_step_decoder #(
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample,
  input  logic [2:0] code_in,
  output logic [2:0] position,
  output logic       dir,
  output logic       locked,
  output logic       step_err,
  output logic [7:0] err_cnt,
  output logic [1:0] o_dbg_state,
  output logic [3:0] o_dbg_run_cnt
);

  // Debug state encoding is fixed: IDLE=0, ACQ=1, LOCK=2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LP_LOCK_CNT = 4'(LOCK_CNT);

  state_t     r_state;
  logic [2:0] r_position;
  logic       r_dir;
  logic       r_locked;
  logic       r_step_err;
  logic [7:0] r_err_cnt;
  logic [3:0] r_run_cnt;

  logic [2:0] w_bin;
  logic [2:0] w_delta;
  logic       w_up;
  logic       w_down;
  logic       w_legal;
  logic       w_illegal;
  logic [3:0] w_next_run;

  // Handshake: sample is a one-cycle strobe with no back-pressure; code_in is
  // consumed on every rising edge where sample=1 and ignored otherwise.
  assign w_bin     = {code_in[2],
                      code_in[2] ^ code_in[1],
                      code_in[2] ^ code_in[1] ^ code_in[0]};
  assign w_delta   = w_bin - r_position;
  assign w_up      = (w_delta == 3'd1);
  assign w_down    = (w_delta == 3'd7);
  assign w_legal   = w_up | w_down;
  assign w_illegal = (w_delta != 3'd0) && !w_legal;

  // A reversal during acquisition restarts the run at one.
  assign w_next_run = ((r_run_cnt == 4'd0) || (w_up == r_dir)) ?
                      (r_run_cnt + 4'd1) : 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_position <= 3'd0;
      r_dir      <= 1'b0;
      r_locked   <= 1'b0;
      r_step_err <= 1'b0;
      r_err_cnt  <= 8'd0;
      r_run_cnt  <= 4'd0;
    end else begin
      r_step_err <= 1'b0;
      if (sample) begin
        case (r_state)
          IDLE: begin
            r_position <= w_bin;
            r_run_cnt  <= 4'd0;
            r_state    <= ACQ;
          end
          ACQ: begin
            if (w_legal) begin
              r_position <= w_bin;
              r_dir      <= w_up;
              r_run_cnt  <= w_next_run;
              if (w_next_run == LP_LOCK_CNT) begin
                r_state  <= LOCK;
                r_locked <= 1'b1;
              end
            end else if (w_illegal) begin
              r_step_err <= 1'b1;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_position <= w_bin;
              r_run_cnt  <= 4'd0;
            end
          end
          LOCK: begin
            if (w_legal) begin
              r_position <= w_bin;
              r_dir      <= w_up;
            end else if (w_illegal) begin
              r_step_err <= 1'b1;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_position <= w_bin;
              r_run_cnt  <= 4'd0;
              r_locked   <= 1'b0;
              r_state    <= ACQ;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign position      = r_position;
  assign dir           = r_dir;
  assign locked        = r_locked;
  assign step_err      = r_step_err;
  assign err_cnt       = r_err_cnt;
  assign o_dbg_state   = r_state;
  assign o_dbg_run_cnt = r_run_cnt;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Bench for gray_step_decoder: directed scenarios plus randomized steps checked
// against a table-driven reference model through an expected-value queue.
module tb_gray_step_decoder;

  localparam int LOCK_CNT = 4;

  logic       clk;
  logic       reset;
  logic       sample;
  logic [2:0] code_in;
  logic [2:0] position;
  logic       dir;
  logic       locked;
  logic       step_err;
  logic [7:0] err_cnt;
  logic [1:0] dbg_state;
  logic [3:0] dbg_run_cnt;

  gray_step_decoder #(.LOCK_CNT(LOCK_CNT)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample        (sample),
    .code_in       (code_in),
    .position      (position),
    .dir           (dir),
    .locked        (locked),
    .step_err      (step_err),
    .err_cnt       (err_cnt),
    .o_dbg_state   (dbg_state),
    .o_dbg_run_cnt (dbg_run_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Up-counting Gray sequence: index = binary value.
  int gray_seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  int m_mode;     // 0 idle, 1 acquiring, 2 locked
  int m_pos;
  int m_dir;
  int m_streak;
  int m_errs;
  int m_pulse;

  function automatic int gray_to_bin(input int code);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (gray_seq[i] == code) r = i;
    return r;
  endfunction

  task automatic model_edge(input logic rst, input logic smp, input int code);
    int b, d, up;
    m_pulse = 0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_dir = 0; m_streak = 0; m_errs = 0;
    end else if (smp) begin
      b = gray_to_bin(code);
      if (m_mode == 0) begin
        m_pos = b; m_streak = 0; m_mode = 1;
      end else begin
        d = (b - m_pos + 8) % 8;
        if (d == 1 || d == 7) begin
          up = (d == 1) ? 1 : 0;
          if (m_mode == 1) begin
            m_streak = (m_streak == 0 || up == m_dir) ? m_streak + 1 : 1;
            if (m_streak == LOCK_CNT) m_mode = 2;
          end
          m_dir = up;
          m_pos = b;
        end else if (d != 0) begin
          m_pulse = 1;
          m_errs  = (m_errs < 255) ? m_errs + 1 : 255;
          m_pos   = b;
          m_streak = 0;
          m_mode  = 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  // Packed expectation: {state[2], run[4], pos[3], dir, locked, err, cnt[8]}
  logic [19:0] exp_q[$];
  int n_total;
  int n_bad;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [19:0] model_pack();
    logic [19:0] p;
    p[19:18] = 2'(m_mode);
    p[17:14] = 4'(m_streak);
    p[13:11] = 3'(m_pos);
    p[10]    = 1'(m_dir);
    p[9]     = (m_mode == 2);
    p[8]     = 1'(m_pulse);
    p[7:0]   = 8'(m_errs);
    return p;
  endfunction

  task automatic compare_outputs();
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("state",    dbg_state,   e[19:18]);
      check_val("run_cnt",  dbg_run_cnt, e[17:14]);
      check_val("position", position,    e[13:11]);
      check_val("dir",      dir,         e[10]);
      check_val("locked",   locked,      e[9]);
      check_val("step_err", step_err,    e[8]);
      check_val("err_cnt",  err_cnt,     e[7:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic smp, input int code);
    @(negedge clk);
    reset   = rst;
    sample  = smp;
    code_in = 3'(code);
    @(posedge clk);
    model_edge(rst, smp, code);
    exp_q.push_back(model_pack());
    #1;
    compare_outputs();
  endtask

  task automatic samp_bin(input int b);
    drive(1'b0, 1'b1, gray_seq[b & 7]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b, r, k;
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1; sample = 1'b0; code_in = 3'd0;
    m_mode = 0; m_pos = 0; m_dir = 0; m_streak = 0; m_errs = 0; m_pulse = 0;

    drive(1'b1, 1'b0, 0);
    check_val("reset_locked", locked, 1'b0);
    check_val("reset_pos", position, 3'd0);

    // Up-lock: codes 000,001,011,010,110
    samp_bin(0); samp_bin(1); samp_bin(2); samp_bin(3); samp_bin(4);
    check_val("uplock_locked", locked, 1'b1);
    check_val("uplock_pos", position, 3'd4);
    check_val("uplock_dir", dir, 1'b1);
    check_val("uplock_errs", err_cnt, 8'd0);

    // Reversal in lock: 010 then 011
    samp_bin(3); samp_bin(2);
    check_val("rev_pos", position, 3'd2);
    check_val("rev_dir", dir, 1'b0);
    check_val("rev_locked", locked, 1'b1);

    // Illegal jump 011 -> 111 (bin 5)
    drive(1'b0, 1'b1, 3'b111);
    check_val("jump_err", step_err, 1'b1);
    check_val("jump_cnt", err_cnt, 8'd1);
    check_val("jump_locked", locked, 1'b0);
    check_val("jump_pos", position, 3'd5);
    samp_bin(6);
    check_val("jump_err_gone", step_err, 1'b0);
    samp_bin(7); samp_bin(0);
    check_val("relock_not_yet", locked, 1'b0);
    samp_bin(1);
    check_val("relock", locked, 1'b1);

    // Hold and gaps
    for (int i = 0; i < 5; i++) samp_bin(1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, $urandom_range(0, 7));
    check_val("hold_pos", position, 3'd1);
    check_val("hold_locked", locked, 1'b1);

    // ACQ direction restart
    drive(1'b1, 1'b0, 0);
    samp_bin(0); samp_bin(1); samp_bin(2); samp_bin(1);
    check_val("restart_run", dbg_run_cnt, 4'd1);
    check_val("restart_dir", dir, 1'b0);
    samp_bin(0); samp_bin(7); samp_bin(6);
    check_val("down_lock", locked, 1'b1);
    check_val("down_pos", position, 3'd6);

    // Reset with sample, then error saturation
    drive(1'b1, 1'b1, 3'b101);
    check_val("rst_smp_state", dbg_state, 2'd0);
    check_val("rst_smp_pos", position, 3'd0);
    samp_bin(0);
    for (int i = 0; i < 300; i++) samp_bin((i % 2 == 0) ? 4 : 0);
    check_val("sat_cnt", err_cnt, 8'd255);
    samp_bin(4);
    check_val("sat_hold", err_cnt, 8'd255);

    // Randomized phase: mostly legal steps, some holds, jumps, gaps and resets
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive(1'b1, $urandom_range(0, 1), $urandom_range(0, 7));
      end else if (r < 12) begin
        drive(1'b0, 1'b0, $urandom_range(0, 7));
      end else begin
        k = $urandom_range(0, 9);
        if (k < 4)      b = m_pos + 1;
        else if (k < 7) b = m_pos + 7;
        else if (k < 8) b = m_pos;
        else            b = $urandom_range(0, 7);
        samp_bin(b);
      end
    end

    check_val("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_step_decoder.md
GRAY_STEP_DECODER -- requirements
Module: gray_step_decoder

Interface
REQ-001 SHALL have parameter: LOCK_CNT, default 4, number of consecutive legal same-direction steps needed to lock; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: sample  input  1  strobe; code_in is valid this cycle.
REQ-005 SHALL have port: code_in  input  3  3-bit reflected Gray code from a mode-controlled up/down counter.
REQ-006 SHALL have port: position  output  3  binary value of the last accepted code.
REQ-007 SHALL have port: dir  output  1  direction of the last legal non-zero step (1 = up, 0 = down).
REQ-008 SHALL have port: locked  output  1  high while the FSM is in LOCK.
REQ-009 SHALL have port: step_err  output  1  one-cycle pulse on an illegal transition.
REQ-010 SHALL have port: err_cnt  output  8  saturating count of illegal transitions.

Function
REQ-011 SHALL decode Gray to binary as: b2=g2, b1=g2^g1, b0=g2^g1^g0. The up sequence is 000,001,011,010,110,111,101,100, wrapping to 000.
REQ-012 SHALL compute delta = (bin(code_in) - position) mod 8 on every sampled cycle.
REQ-013 SHALL classify delta as follows:
  - 0: hold.
  - 1: up step.
  - 7: down step.
  - Any other value: illegal.
REQ-014 SHALL ignore code_in entirely when sample=0; all state holds.
REQ-015 SHALL have all outputs registered: a sample taken at edge k is reflected on the outputs immediately after edge k (latency 1).
REQ-016 SHALL implement an FSM with states IDLE, ACQ and LOCK, plus an internal 4-bit run_cnt.
REQ-017 In IDLE, on sample, SHALL: position <= bin(code_in); run_cnt <= 0; go to ACQ. No error is possible in IDLE.
REQ-018 In ACQ or LOCK, on a hold, SHALL leave position, dir, run_cnt and state unchanged.
REQ-019 In ACQ, on a legal step, SHALL:
  - Update position.
  - If run_cnt=0 or the step direction equals dir: run_cnt <= run_cnt+1.
  - Otherwise: run_cnt <= 1.
  - dir <= step direction.
  - Go to LOCK in the same edge that run_cnt reaches LOCK_CNT.
REQ-020 In LOCK, on a legal step, SHALL update position and dir and remain in LOCK; direction reversal is legal.
REQ-021 In ACQ or LOCK, on an illegal step, SHALL:
  - Pulse step_err for exactly one cycle.
  - err_cnt <= err_cnt+1 (saturates at 255).
  - position <= bin(code_in), as a re-reference.
  - run_cnt <= 0.
  - Go to ACQ; dir is unchanged.
REQ-022 SHALL drive locked high only in LOCK; it SHALL fall in the cycle after the edge that detected an illegal step.
REQ-023 SHALL drive step_err low on every cycle not covered by REQ-021, including consecutive hold samples.
REQ-024 SHALL wrap position modulo 8: 100 -> 000 is an up step; 000 -> 100 is a down step.

Reset
REQ-025 On reset=1 at a rising edge, SHALL set: state=IDLE, position=0, dir=0, locked=0, step_err=0, err_cnt=0, run_cnt=0.
REQ-026 SHALL give reset priority over sample at the same edge; that sample is discarded.
REQ-027 SHALL return to IDLE on reset asserted mid-operation (ACQ or LOCK), with the full reset values of REQ-025 on the next edge; err_cnt is cleared.

Verification (LOCK_CNT=4)
REQ-028 Up-lock: reset, then sample 000,001,011,010,110 on consecutive cycles -> after the 5th edge, locked=1, position=4, dir=1, err_cnt=0.
REQ-029 Reversal in lock: continue from REQ-028 with 010, then 011 -> position=3 then 2, dir=0, locked stays 1, step_err never high.
REQ-030 Illegal jump: locked at position=2 (code 011), then sample 111 (delta 3) -> step_err=1 for one cycle, err_cnt=1, locked=0, position=5; then 4 legal up steps -> locked=1.
REQ-031 ACQ direction restart: from IDLE, sample 000,001,011 (2 up), then 001 (down) -> run_cnt=1, dir=0, locked=0; 3 further down steps 000,100,101 -> locked=1, position=6.
REQ-032 Hold and gaps: in LOCK, repeat the same code with sample=1 for 5 cycles, then change code_in with sample=0 for 5 cycles -> no output changes.
REQ-033 Reset and saturation: assert reset together with sample -> all outputs 0, state IDLE; 300 illegal steps -> err_cnt=255 and holds.
